// File: rtl/adc_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_master
// Brief    : 3-wire SPI master (mode 0, MSB first) for the AD9434 config port.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_master #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int CLK_DIV         = 4,
    parameter int CS_SETUP        = 2,
    parameter int CS_HOLD         = 2,
    parameter int CS_GAP          = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_spi_wr_cmd,
    input  logic                       i_spi_rd_cmd,
    input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
    output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
    output logic                       o_spi_rd_valid,
    output logic                       o_spi_busy,
    output logic                       o_sclk,
    output logic                       o_csb,
    output logic                       o_sdio_out,
    output logic                       o_sdio_oe,
    input  logic                       i_sdio_in
);

    localparam int BIT_W    = $clog2(MOSI_DATA_WIDTH);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                   : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST  = BIT_W'(MOSI_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  RX_BITS    = BIT_W'(MISO_DATA_WIDTH);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                     r_state, w_state;
    logic [WAIT_W-1:0]          r_wait, w_wait;
    logic [DIV_W-1:0]           r_div, w_div;
    logic                       r_phase, w_phase;
    logic [BIT_W-1:0]           r_bit, w_bit;
    logic [MOSI_DATA_WIDTH-1:0] r_shift, w_shift;
    logic                       r_rd, w_rd;
    logic [MISO_DATA_WIDTH-1:0] r_rx, w_rx, w_rx_shift;
    logic [MISO_DATA_WIDTH-1:0] r_rd_data, w_rd_data;
    logic                       r_rd_valid, w_rd_valid;
    logic                       r_busy, w_busy;
    logic                       r_sclk, w_sclk;
    logic                       r_csb, w_csb;
    logic                       r_sdio_out, w_sdio_out;
    logic                       r_sdio_oe, w_sdio_oe;

    generate
        if (MISO_DATA_WIDTH > 1) begin : g_rx_multi
            assign w_rx_shift = {r_rx[MISO_DATA_WIDTH-2:0], i_sdio_in};
        end else begin : g_rx_single
            assign w_rx_shift = i_sdio_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_div      <= '0;
            r_phase    <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rd       <= 1'b0;
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_csb      <= 1'b1;
            r_sdio_out <= 1'b0;
            r_sdio_oe  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_wait     <= w_wait;
            r_div      <= w_div;
            r_phase    <= w_phase;
            r_bit      <= w_bit;
            r_shift    <= w_shift;
            r_rd       <= w_rd;
            r_rx       <= w_rx;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_valid;
            r_busy     <= w_busy;
            r_sclk     <= w_sclk;
            r_csb      <= w_csb;
            r_sdio_out <= w_sdio_out;
            r_sdio_oe  <= w_sdio_oe;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_wait     = r_wait;
        w_div      = r_div;
        w_phase    = r_phase;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_rd       = r_rd;
        w_rx       = r_rx;
        w_rd_data  = r_rd_data;
        w_rd_valid = 1'b0;
        w_busy     = r_busy;
        w_sclk     = r_sclk;
        w_csb      = r_csb;
        w_sdio_out = r_sdio_out;
        w_sdio_oe  = r_sdio_oe;

        case (r_state)
            S_IDLE: begin
                if ((i_spi_wr_cmd || i_spi_rd_cmd) && !r_busy) begin
                    w_shift    = i_spi_wr_data;
                    w_rd       = i_spi_rd_cmd;
                    w_busy     = 1'b1;
                    w_csb      = 1'b0;
                    w_sdio_oe  = 1'b1;
                    w_sdio_out = i_spi_wr_data[MOSI_DATA_WIDTH-1];
                    w_bit      = BIT_FIRST;
                    w_wait     = '0;
                    w_state    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (r_wait == SETUP_LAST) begin
                    w_div   = '0;
                    w_phase = 1'b0;
                    w_state = S_SHIFT;
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end

            S_SHIFT: begin
                if (r_div != DIV_LAST) begin
                    w_div = r_div + 1'b1;
                end else begin
                    w_div = '0;
                    if (!r_phase) begin
                        // Rising SCLK edge: slave data has been stable for a full low phase.
                        w_phase = 1'b1;
                        w_sclk  = 1'b1;
                        if (r_rd && (r_bit < RX_BITS)) begin
                            w_rx = w_rx_shift;
                        end
                    end else begin
                        w_phase = 1'b0;
                        w_sclk  = 1'b0;
                        if (r_bit == '0) begin
                            w_wait  = '0;
                            w_state = S_HOLD;
                        end else begin
                            w_bit   = r_bit - 1'b1;
                            w_shift = r_shift << 1;
                            // Turn the bus around once the instruction bits are out.
                            if (r_rd && (w_bit < RX_BITS)) begin
                                w_sdio_oe  = 1'b0;
                                w_sdio_out = 1'b0;
                            end else begin
                                w_sdio_out = w_shift[MOSI_DATA_WIDTH-1];
                            end
                        end
                    end
                end
            end

            S_HOLD: begin
                if (r_wait == HOLD_LAST) begin
                    w_csb      = 1'b1;
                    w_sdio_oe  = 1'b0;
                    w_sdio_out = 1'b0;
                    if (r_rd) begin
                        w_rd_data  = r_rx;
                        w_rd_valid = 1'b1;
                    end
                    w_wait  = '0;
                    w_state = S_GAP;
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end

            S_GAP: begin
                if (r_wait == GAP_LAST) begin
                    w_busy  = 1'b0;
                    w_wait  = '0;
                    w_state = S_IDLE;
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_spi_rd_data  = r_rd_data;
    assign o_spi_rd_valid = r_rd_valid;
    assign o_spi_busy     = r_busy;
    assign o_sclk         = r_sclk;
    assign o_csb          = r_csb;
    assign o_sdio_out     = r_sdio_out;
    assign o_sdio_oe      = r_sdio_oe;

endmodule
`default_nettype wire
